// File: rtl/risc_v_def.sv
// Shared definitions for the register-file debug dump reader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package risc_v_def;

  // Dump FSM states; CSUM is only reachable when the checksum beat is built in.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4
  } dump_state_t;

  // Index reported on the checksum beat: all ones, sliced down to the address width.
  localparam logic [31:0] DUMP_CSUM_IDX = '1;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks register-file debug port 0..2**ADDR_W-1 and streams {idx,data,last}; optional XOR checksum beat under REGDUMP_CHECKSUM_EN.
// Latency: first beat valid 2 cycles after start is sampled; 1 beat per 2 cycles at best.
// Backpressure: payload held stable in SEND until out_valid & out_ready; no beat is skipped or repeated.
module regfile_dump_reader
  import risc_v_def::*;
#(
  parameter int ADDR_W = 5,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] debug_ra,
  input  logic [XLEN-1:0]   debug_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;
`ifdef REGDUMP_CHECKSUM_EN
  logic [XLEN-1:0]   csum_q, csum_d;
`endif

  // State, index and output payload registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Next-state logic: walk the index, capture each register in FETCH, hold it in SEND.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
`ifdef REGDUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = FETCH;
`ifdef REGDUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      FETCH: begin
        // The register file write port is registered, so a same-cycle write is not seen here.
        out_data_d  = debug_rd;
        out_idx_d   = idx_q;
`ifdef REGDUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = (idx_q == LAST_IDX);
`endif
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
          csum_d      = csum_q ^ out_data_q;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            // Terminal test is on all ones, so idx never wraps inside a dump.
            idx_d   = idx_q + IDX_ONE;
            state_d = FETCH;
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      CSUM: begin
        // First cycle loads the checksum beat; then wait for its handshake.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = csum_q;
          out_idx_d   = DUMP_CSUM_IDX[ADDR_W-1:0];
          out_last_d  = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = DONE;
        end
      end
`endif
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign debug_ra  = idx_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug reader that sits on the register file's debug read port (debug_ra / debug_rd).
- On a start pulse it walks every architectural register address in ascending order, 0 to 2**ADDR_W-1.
- It streams each value out on a valid/ready interface, with the register index and a last flag, to a debug host link such as a UART bridge or trace FIFO.
- It is the consumer end of the debug read interface. It never writes the register file.

Parameters:
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers are dumped.
- XLEN, 32, register data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  dump request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final beat is accepted.
- debug_ra  out  ADDR_W  address driven to the register file debug port.
- debug_rd  in  XLEN  combinational read data returned for debug_ra.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  XLEN  register value.
- out_idx  out  ADDR_W  register index of the beat (checksum beat: all ones).
- out_last  out  1  marks the final beat of a dump.

Behaviour:
- Reset values: state=IDLE, idx=0, busy=0, done=0, out_valid=0, out_data=0, out_idx=0, out_last=0, debug_ra=0. Reset mid-dump abandons the dump immediately; no done pulse is produced.
- debug_ra is driven from the idx register in every state.
- FSM states: IDLE, FETCH, SEND, DONE (plus CSUM under the optional feature).
- IDLE: start=1 -> idx<=0, go to FETCH. start=0 -> stay.
- FETCH (1 cycle): out_data<=debug_rd, out_idx<=idx, out_last<=(idx==NREG-1 and no checksum beat), out_valid<=1, go to SEND.
- SEND: hold out_valid and all payload stable until out_valid & out_ready.
  - On handshake with idx==NREG-1: go to DONE (or CSUM), out_valid<=0.
  - Otherwise: idx<=idx+1, out_valid<=0, go to FETCH.
- DONE: done=1 for exactly this cycle, idx<=0, go to IDLE.
- Latency: first beat valid 2 cycles after start is sampled. Best-case throughput is 1 beat per 2 cycles, with out_ready held high.
- Index 0 is read through the debug port like any other register. Its value is whatever the debug port returns; no forced zero is applied here.
- idx never wraps during a dump; the terminal test uses NREG-1 (all ones).
- start while busy: ignored, no queuing. start in the DONE cycle: ignored.
- Each value is sampled in its own FETCH cycle, so the dump is not atomic. A register written before its FETCH cycle shows the new value; one written after shows the old value. A write in the same cycle as FETCH shows the old value, because the register-file write is registered.
- out_ready is don't-care while out_valid=0.

Optional Feature:
- Macro: REGDUMP_CHECKSUM_EN.
- Defined:
  - A XLEN-bit accumulator is cleared on start and XORs each register beat's out_data at its handshake.
  - After beat NREG-1 the FSM enters CSUM, then presents one extra beat: out_data=accumulator, out_idx=all ones, out_last=1.
  - Register beat NREG-1 has out_last=0.
  - When the CSUM beat is accepted, the FSM goes to DONE.
- Undefined: no accumulator, no CSUM state; register beat NREG-1 carries out_last=1.

Decomposition:
- Shared package (risc_v_def): dump_state_t enum {IDLE, FETCH, SEND, CSUM, DONE}, and a DUMP_CSUM_IDX constant (all ones).
- No sub-module is needed; FSM, index counter and output register live in one module.

Test Plan:
- Preload r1=0x11111111, r31=0xDEADBEEF, others 0; pulse start with out_ready=1 -> 32 beats with idx 0..31, r31 beat data 0xDEADBEEF and out_last=1, done pulse one cycle after that beat, busy low afterwards.
- Backpressure: drop out_ready for 5 cycles while beat idx=3 is valid -> out_valid, out_data and out_idx stay stable; no beat is lost or duplicated; full dump still has 32 beats.
- start pulsed again at beat 10 -> ignored; exactly 32 beats and one done pulse.
- rst asserted while beat idx=7 is pending -> next cycle out_valid=0, busy=0; a new start dumps from idx 0.
- Write r5=0xCAFEF00D while idx=2 -> beat idx=5 carries 0xCAFEF00D.
- REGDUMP_CHECKSUM_EN with r1=0x0F0F0000, r2=0x00F0F0FF, others 0 -> 33rd beat has idx=31 (all ones), data=0x0FFFF0FF, out_last=1; beat 31 has out_last=0.
